tc_mb_scheduler: RTL and testbench

- Sequences one macroblock's 24 residual 4x4 blocks through the transformcoder datapath: 16 luma, then 4 Cb, then 4 Cr.
- Accepts residual blocks from intra/inter prediction over a valid/ready handshake.
- Drives transformcoder enable, residuals and QP, and applies the correct luma or chroma QP per block.
- Tags results in order with their block index and delivers them downstream (entropy coder) with backpressure.

---
 rtl/tc_sched_pkg.sv | 50 +++++
 rtl/tc_tag_pipe.sv | 29 ++
 rtl/tc_mb_scheduler.sv | 116 +++++++++++
 tb/tb_tc_mb_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_sched_pkg.sv
// Shared types, block-count constants and QP helpers for the macroblock scheduler.
package tc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef logic [4:0] blk_idx_t;

    typedef struct packed {
        logic     valid;
        blk_idx_t idx;
        logic     coded;
    } tag_t;

    localparam int NUM_LUMA_BLK = 16;
    localparam int NUM_BLK      = 24;
    localparam int QP_MAX       = 51;

    function automatic int clip_qp(input int v);
        if (v < 0)
            return 0;
        if (v > QP_MAX)
            return QP_MAX;
        return v;
    endfunction

    // H.264 QPi -> QPc mapping; identity below 30.
    function automatic logic [5:0] chroma_map(input int qpi);
        logic [5:0] r_map;
        case (qpi)
            30:             r_map = 6'd29;
            31:             r_map = 6'd30;
            32:             r_map = 6'd31;
            33, 34:         r_map = 6'd32;
            35:             r_map = 6'd33;
            36, 37:         r_map = 6'd34;
            38, 39:         r_map = 6'd35;
            40, 41:         r_map = 6'd36;
            42, 43, 44:     r_map = 6'd37;
            45, 46, 47:     r_map = 6'd38;
            48, 49, 50, 51: r_map = 6'd39;
            default:        r_map = 6'(qpi);
        endcase
        return r_map;
    endfunction

endpackage

// File: rtl/tc_tag_pipe.sv
// Enable-gated shift register of block tags that runs alongside the transformcoder pipeline.
module tc_tag_pipe
    import tc_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_stage[i] <= '0;
        end else if (i_en) begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++)
                r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/tc_mb_scheduler.sv
// Sequences 16 luma + 4 Cb + 4 Cr residual blocks through the transformcoder and tags results.
// Optional macro TC_SKIP_ZERO_EN: all-zero blocks bypass the transform and emit zero coefficients.
module tc_mb_scheduler
    import tc_sched_pkg::*;
#(
    parameter int BIT_LENGTH       = 31,
    parameter int TC_LATENCY       = 2,
    parameter int CHROMA_QP_OFFSET = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [5:0]                 qp_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0][BIT_LENGTH:0]  in_res,
    output logic                       tc_enable,
    output logic [15:0][BIT_LENGTH:0]  tc_residuals,
    output logic [5:0]                 tc_qp,
    input  logic [15:0][BIT_LENGTH:0]  tc_processed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0][BIT_LENGTH:0]  out_coeffs,
    output logic [4:0]                 out_blk_idx,
    output logic                       out_coded,
    output logic                       busy,
    output logic                       mb_done
);

    sched_state_t r_state;
    sched_state_t w_state_next;
    blk_idx_t     r_issue_cnt;
    logic [5:0]   r_qp;
    logic [5:0]   r_qpc;
    logic [5:0]   w_qpc_calc;
    int           w_qpi_sum;
    tag_t         w_tag_in;
    tag_t         w_tag_out;
    logic         w_stall;
    logic         w_issue;
    logic         w_coded;
    logic         w_last_out;

    assign busy       = (r_state != IDLE);
    assign w_stall    = w_tag_out.valid && !out_ready;
    assign tc_enable  = busy && !w_stall;
    assign in_ready   = (r_state == RUN) && !w_stall && (r_issue_cnt < 5'(NUM_BLK));
    assign w_issue    = in_valid && in_ready;
    assign w_coded    = |in_res;
    assign w_last_out = w_tag_out.valid && out_ready && (w_tag_out.idx == 5'(NUM_BLK - 1));
    assign mb_done    = (r_state == DRAIN) && w_last_out;
    assign tc_qp      = (r_issue_cnt < 5'(NUM_LUMA_BLK)) ? r_qp : r_qpc;

    always_comb begin
        w_qpi_sum  = int'({26'd0, qp_in}) + CHROMA_QP_OFFSET;
        w_qpc_calc = chroma_map(clip_qp(w_qpi_sum));
    end

    // Bubbles load an all-zero tag so idle stages never expose stale index/coded bits.
    always_comb begin
        w_tag_in.valid = w_issue;
        w_tag_in.idx   = w_issue ? r_issue_cnt : '0;
        w_tag_in.coded = w_issue && w_coded;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_issue && (r_issue_cnt == 5'(NUM_BLK - 1))) w_state_next = DRAIN;
            DRAIN:   if (w_last_out) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_qp        <= '0;
            r_qpc       <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && start) begin
                r_qp        <= qp_in;
                r_qpc       <= w_qpc_calc;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 5'd1;
            end
        end
    end

    tc_tag_pipe #(
        .DEPTH (TC_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (reset),
        .i_en  (tc_enable),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign out_valid   = w_tag_out.valid;
    assign out_blk_idx = w_tag_out.idx;
    assign out_coded   = w_tag_out.coded;

`ifdef TC_SKIP_ZERO_EN
    assign tc_residuals = (busy && w_coded) ? in_res : '0;
    assign out_coeffs   = (w_tag_out.valid && w_tag_out.coded) ? tc_processed : '0;
`else
    assign tc_residuals = busy ? in_res : '0;
    assign out_coeffs   = w_tag_out.valid ? tc_processed : '0;
`endif

endmodule

// File: tb/tb_tc_mb_scheduler.sv
// Randomized bench: transaction-level reference model of the macroblock scheduler.
module tb_tc_mb_scheduler;

    localparam int BL   = 31;
    localparam int W    = BL + 1;
    localparam int LAT  = 2;
    localparam int OFF2 = 12;

    typedef logic [15:0][W-1:0] blk_t;
    typedef struct {
        int   idx;
        bit   coded;
        blk_t coeffs;
        int   acc_en;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] qp_in;
    logic       in_valid;
    logic       out_ready;
    blk_t       in_res;
    blk_t       tc_processed;

    logic       in_ready, tc_enable, out_valid, out_coded, busy, mb_done;
    blk_t       tc_residuals, out_coeffs;
    logic [5:0] tc_qp;
    logic [4:0] out_blk_idx;

    logic       off_in_ready, off_tc_enable, off_out_valid, off_out_coded, off_busy, off_mb_done;
    blk_t       off_tc_residuals, off_out_coeffs;
    logic [5:0] off_tc_qp;
    logic [4:0] off_out_blk_idx;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    int   sent;
    int   en_cnt;
    bit   active;
    int   mb_qp;
    int   stall_left;
    blk_t blks [24];
    blk_t tc_pipe [LAT];

    tc_mb_scheduler #(.BIT_LENGTH(BL), .TC_LATENCY(LAT), .CHROMA_QP_OFFSET(0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .qp_in(qp_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res),
        .tc_enable(tc_enable), .tc_residuals(tc_residuals), .tc_qp(tc_qp),
        .tc_processed(tc_processed), .out_valid(out_valid), .out_ready(out_ready),
        .out_coeffs(out_coeffs), .out_blk_idx(out_blk_idx), .out_coded(out_coded),
        .busy(busy), .mb_done(mb_done)
    );

    tc_mb_scheduler #(.BIT_LENGTH(BL), .TC_LATENCY(LAT), .CHROMA_QP_OFFSET(OFF2)) u_dut_off (
        .clk(clk), .reset(reset), .start(start), .qp_in(qp_in),
        .in_valid(in_valid), .in_ready(off_in_ready), .in_res(in_res),
        .tc_enable(off_tc_enable), .tc_residuals(off_tc_residuals), .tc_qp(off_tc_qp),
        .tc_processed(tc_processed), .out_valid(off_out_valid), .out_ready(out_ready),
        .out_coeffs(off_out_coeffs), .out_blk_idx(off_out_blk_idx), .out_coded(off_out_coded),
        .busy(off_busy), .mb_done(off_mb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic blk_t tc_fn(input blk_t r, input logic [5:0] qv);
        blk_t o;
        for (int j = 0; j < 16; j++)
            o[j] = r[j] * 32'd3 + {26'd0, qv} + 32'(j);
        return o;
    endfunction

    // Transformcoder stand-in: LAT enabled cycles of delay.
    always @(posedge clk) begin
        if (tc_enable) begin
            tc_pipe[0] <= tc_fn(tc_residuals, tc_qp);
            for (int i = 1; i < LAT; i++)
                tc_pipe[i] <= tc_pipe[i-1];
        end
    end
    assign tc_processed = tc_pipe[LAT-1];

    function automatic int qpc_ref(input int qpv, input int off);
        int tab [22] = '{29, 30, 31, 32, 32, 33, 34, 34, 35, 35, 36,
                         36, 37, 37, 37, 38, 38, 38, 39, 39, 39, 39};
        int v;
        v = qpv + off;
        if (v < 0)  v = 0;
        if (v > 51) v = 51;
        return (v < 30) ? v : tab[v-30];
    endfunction

    function automatic int qp_for(input int idx, input int qpv, input int off);
        return (idx < 16) ? qpv : qpc_ref(qpv, off);
    endfunction

    function automatic blk_t exp_coeff(input blk_t r, input int qpv);
`ifdef TC_SKIP_ZERO_EN
        if (r == '0)
            return '0;
`endif
        return tc_fn(r, 6'(qpv));
    endfunction

    function automatic blk_t exp_tc_res(input blk_t r);
`ifdef TC_SKIP_ZERO_EN
        if (r == '0)
            return '0;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string ph);
        chk({ph, "_in_ready"},   512'(in_ready),    512'(0));
        chk({ph, "_tc_enable"},  512'(tc_enable),   512'(0));
        chk({ph, "_out_valid"},  512'(out_valid),   512'(0));
        chk({ph, "_busy"},       512'(busy),        512'(0));
        chk({ph, "_mb_done"},    512'(mb_done),     512'(0));
        chk({ph, "_blk_idx"},    512'(out_blk_idx), 512'(0));
        chk({ph, "_coded"},      512'(out_coded),   512'(0));
        chk({ph, "_tc_qp"},      512'(tc_qp),       512'(0));
        chk({ph, "_coeffs"},     512'(out_coeffs),  512'(0));
        chk({ph, "_tc_res"},     512'(tc_residuals), 512'(0));
        chk({ph, "_off_busy"},   512'(off_busy),    512'(0));
        chk({ph, "_off_valid"},  512'(off_out_valid), 512'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        #1;
        check_reset_outputs("rst");
        q.delete();
        active = 0;
        sent   = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic begin_mb(input int qpv);
        for (int k = 0; k < 24; k++) begin
            for (int j = 0; j < 16; j++)
                blks[k][j] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            if (k == 5 || $urandom_range(0, 7) == 0)
                blks[k] = '0;
        end
        @(negedge clk);
        start     = 1'b1;
        qp_in     = 6'(qpv);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("idle_busy",      512'(busy),      512'(0));
        chk("idle_in_ready",  512'(in_ready),  512'(0));
        chk("idle_tc_enable", 512'(tc_enable), 512'(0));
        chk("idle_out_valid", 512'(out_valid), 512'(0));
        mb_qp  = qpv;
        sent   = 0;
        active = 1;
    endtask

    task automatic step(input int mode, input int c);
        bit   ov, stall, en_e, rdy_e, fire, done_e, issue, want_v, rdy;
        int   qe;
        exp_t e;
        @(negedge clk);
        start  = 1'b0;
        qp_in  = 6'($urandom_range(0, 51));
        ov     = (q.size() > 0) && (en_cnt - q[0].acc_en >= LAT);
        want_v = (mode == 1) ? ((c % 2) == 0) : (mode == 3) ? ($urandom_range(0, 9) < 7) : 1'b1;
        rdy    = (mode == 3) ? ($urandom_range(0, 9) < 7) : 1'b1;
        if (mode == 2 && ov && q[0].idx == 7 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
        end
        in_valid  = want_v && active && (sent < 24);
        in_res    = (sent < 24) ? blks[sent] : '0;
        out_ready = rdy;
        #1;
        stall  = ov && !rdy;
        en_e   = active && !stall;
        rdy_e  = en_e && (sent < 24);
        fire   = ov && rdy;
        done_e = fire && (q[0].idx == 23);
        chk("out_valid", 512'(out_valid), 512'(ov));
        chk("busy",      512'(busy),      512'(active));
        chk("tc_enable", 512'(tc_enable), 512'(en_e));
        chk("in_ready",  512'(in_ready),  512'(rdy_e));
        chk("mb_done",   512'(mb_done),   512'(done_e));
        chk("off_in_ready", 512'(off_in_ready),  512'(rdy_e));
        chk("off_tc_en",    512'(off_tc_enable), 512'(en_e));
        chk("off_valid",    512'(off_out_valid), 512'(ov));
        chk("off_mb_done",  512'(off_mb_done),   512'(done_e));
        chk("off_busy",     512'(off_busy),      512'(active));
        if (ov) begin
            chk("blk_idx",    512'(out_blk_idx),     512'(q[0].idx));
            chk("coded",      512'(out_coded),       512'(q[0].coded));
            chk("coeffs",     512'(out_coeffs),      512'(q[0].coeffs));
            chk("off_blk_idx", 512'(off_out_blk_idx), 512'(q[0].idx));
            chk("off_coded",  512'(off_out_coded),   512'(q[0].coded));
            chk("off_coeffs", 512'(off_out_coeffs),  512'(q[0].coeffs));
        end
        if (fire)
            $display("out blk_idx=%0d coded=%0b qp_mb=%0d", q[0].idx, q[0].coded, mb_qp);
        issue = in_valid && rdy_e;
        if (issue) begin
            qe = qp_for(sent, mb_qp, 0);
            chk("tc_qp",      512'(tc_qp),            512'(qe));
            chk("off_tc_qp",  512'(off_tc_qp),        512'(qp_for(sent, mb_qp, OFF2)));
            chk("tc_res",     512'(tc_residuals),     512'(exp_tc_res(blks[sent])));
            chk("off_tc_res", 512'(off_tc_residuals), 512'(exp_tc_res(blks[sent])));
            e.idx    = sent;
            e.coded  = (blks[sent] != '0);
            e.coeffs = exp_coeff(blks[sent], qe);
            e.acc_en = en_cnt;
            q.push_back(e);
            sent++;
        end
        if (fire)
            void'(q.pop_front());
        if (en_e)
            en_cnt++;
        if (done_e)
            active = 0;
    endtask

    // mode: 0 back-to-back, 1 alternate-cycle gaps, 2 five-cycle stall at idx 7,
    // 3 random valid/ready, 4 back-to-back with reset after 10 issued blocks.
    task automatic run_mb(input int qpv, input int mode);
        begin_mb(qpv);
        stall_left = 5;
        for (int c = 0; c < 400 && active; c++) begin
            step((mode == 4) ? 0 : mode, c);
            if (mode == 4 && sent == 10) begin
                do_reset();
                break;
            end
        end
        chk("mb_complete", 512'(active), 512'(0));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        qp_in     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_res    = '0;
        en_cnt    = 0;
        sent      = 0;
        active    = 0;
        mb_qp     = 0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("init");
        @(negedge clk);
        reset = 1'b1;

        run_mb(28, 0);
        run_mb(40, 1);
        run_mb(51, 2);
        run_mb(33, 4);
        run_mb($urandom_range(0, 51), 0);
        run_mb($urandom_range(0, 51), 3);
        run_mb($urandom_range(25, 51), 3);
        run_mb($urandom_range(0, 51), 1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
